lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 69 ++++++
 rtl/lsu_mem_stage.sv | 101 ++++++++++
 tb/tb_lsu_mem_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: RV32I width codes,
// FSM encoding and the access-legality helpers.
package lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_GNT = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } lsu_state_e;

   function automatic logic f3_illegal(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11);
   endfunction

   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (f3)
         F3_H, F3_HU: bad = lo[0];
         F3_W:        bad = (lo != 2'b00);
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication/byte enables on one side,
// load lane extraction and sign/zero extension on the other.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      st_funct3,
   input  logic [1:0]      st_addr_lo,
   input  logic [XLEN-1:0] st_data,
   output logic [3:0]      st_be,
   output logic [XLEN-1:0] st_lanes,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] ld_word,
   output logic [XLEN-1:0] ld_data
);

   function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
      logic signed [7:0]      s;
      logic signed [XLEN-1:0] w;
      s = signed'(b);
      w = s;
      return w;
   endfunction

   function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
      logic signed [15:0]     s;
      logic signed [XLEN-1:0] w;
      s = signed'(h);
      w = s;
      return w;
   endfunction

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_be    = 4'b1111;
      st_lanes = st_data;
      case (st_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << st_addr_lo;
            st_lanes = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_addr_lo)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_funct3)
         F3_B:    ld_data = sext8(ld_byte);
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_H:    ld_data = sext16(ld_half);
         F3_HU:   ld_data = {16'd0, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage of the load/store unit: issues one registered data-bus request
// per op, waits for grant/response, and returns the extended load result.
module lsu_mem_stage
   import lsu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic            op_read,
   input  logic            op_write,
   input  logic [2:0]      op_funct3,
   input  logic [XLEN-1:0] op_addr,
   input  logic [XLEN-1:0] op_wdata,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned
);

   lsu_state_e      state, state_nx;
   logic            access, start, capture;
   logic [2:0]      funct3_p1;
   logic [1:0]      addr_lo_p1;
   logic            is_load_p1;
   logic [3:0]      fmt_be;
   logic [XLEN-1:0] fmt_wdata, ext_data;

   assign access     = op_valid & (op_read | op_write) & (state == ST_IDLE);
   assign misaligned = access & (f3_illegal(op_funct3) | addr_misaligned(op_funct3, op_addr[1:0]));
   assign start      = access & ~misaligned;
   assign stall      = start | (state == ST_WAIT_GNT) | (state == ST_WAIT_RSP);
   // Data arriving together with the grant is taken without visiting WAIT_RSP.
   assign capture    = is_load_p1 & bus_rvalid &
                       (((state == ST_WAIT_GNT) & bus_gnt) | (state == ST_WAIT_RSP));

   lsu_align u_align (
      .st_funct3  (op_funct3),
      .st_addr_lo (op_addr[1:0]),
      .st_data    (op_wdata),
      .st_be      (fmt_be),
      .st_lanes   (fmt_wdata),
      .ld_funct3  (funct3_p1),
      .ld_addr_lo (addr_lo_p1),
      .ld_word    (bus_rdata),
      .ld_data    (ext_data)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (start) state_nx = ST_WAIT_GNT;
         ST_WAIT_GNT: if (bus_gnt) state_nx = (!is_load_p1 || bus_rvalid) ? ST_DONE : ST_WAIT_RSP;
         ST_WAIT_RSP: if (bus_rvalid) state_nx = ST_DONE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
         done      <= 1'b0;
         load_data <= '0;
      end else begin
         state <= state_nx;
         done  <= (state_nx == ST_DONE);
         if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= op_write;
            bus_addr  <= {op_addr[XLEN-1:2], 2'b00};
            bus_be    <= fmt_be;
            bus_wdata <= fmt_wdata;
         end else if ((state == ST_WAIT_GNT) && bus_gnt) begin
            bus_req <= 1'b0;
         end
         if (capture) load_data <= ext_data;
      end
   end

   // Op attributes needed for load extraction after the op inputs move on.
   always_ff @(posedge clk) begin
      if (start) begin
         funct3_p1  <= op_funct3;
         addr_lo_p1 <= op_addr[1:0];
         is_load_p1 <= ~op_write;
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a vector table of single ops plus
// hand-written reset-abort sequences.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid, op_read, op_write;
   logic [2:0]  op_funct3;
   logic [31:0] op_addr, op_wdata;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;
   logic        stall, done, misaligned;
   logic [31:0] load_data;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_load;

   always #5 clk = ~clk;

   lsu_mem_stage dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_read(op_read), .op_write(op_write),
      .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gnt_wait;
      int          rsp_wait;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] lanes;
      logic [31:0] load;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic do_op(input vec_t v, input int idx);
      int   stall_cnt;
      logic is_ld;
      is_ld = ~v.wr;
      @(negedge clk);
      chk("done_idle", idx, 32'(done), 32'd0);
      op_valid = 1'b1; op_read = v.rd; op_write = v.wr; op_funct3 = v.f3;
      op_addr = v.addr; op_wdata = v.wdata; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      #1;
      chk("misaligned", idx, 32'(misaligned), 32'(v.mis));
      if (v.mis) begin
         chk("mis_stall", idx, 32'(stall), 32'd0);
         @(negedge clk);
         chk("mis_req", idx, 32'(bus_req), 32'd0);
         chk("mis_stay_idle", idx, 32'(stall), 32'd0);
         op_valid = 1'b0;
         return;
      end
      stall_cnt = stall ? 1 : 0;
      @(negedge clk);
      chk("req", idx, 32'(bus_req), 32'd1);
      chk("we", idx, 32'(bus_we), 32'(v.wr));
      chk("addr", idx, bus_addr, {v.addr[31:2], 2'b00});
      chk("be", idx, 32'(bus_be), 32'(v.be));
      if (v.wr) chk("wdata", idx, bus_wdata, v.lanes);
      repeat (v.gnt_wait) begin
         if (stall) stall_cnt++;
         @(negedge clk);
         chk("req_held", idx, 32'(bus_req), 32'd1);
         chk("be_held", idx, 32'(bus_be), 32'(v.be));
      end
      bus_gnt = 1'b1;
      if (is_ld && v.rsp_wait == 0) begin
         bus_rvalid = 1'b1;
         bus_rdata  = v.rdata;
      end
      #1;
      if (stall) stall_cnt++;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      #1;
      chk("req_clear", idx, 32'(bus_req), 32'd0);
      if (is_ld && v.rsp_wait > 0) begin
         for (int j = 0; j < v.rsp_wait; j++) begin
            if (j == v.rsp_wait - 1) begin
               bus_rvalid = 1'b1;
               bus_rdata  = v.rdata;
            end else begin
               bus_rdata  = ~v.rdata;
            end
            #1;
            if (stall) stall_cnt++;
            @(negedge clk);
            bus_rvalid = 1'b0;
         end
         #1;
      end
      chk("done", idx, 32'(done), 32'd1);
      chk("done_stall", idx, 32'(stall), 32'd0);
      chk("done_mis", idx, 32'(misaligned), 32'd0);
      if (is_ld) last_load = v.load;
      chk("load_data", idx, load_data, last_load);
      chk("stall_cycles", idx, stall_cnt, 2 + v.gnt_wait + (is_ld ? v.rsp_wait : 0));
      op_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tv[0]  = '{1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000AB, 32'h0,        1, 0, 1'b0, 4'b1000, 32'hABABABAB, 32'h0};
      tv[1]  = '{1'b0, 1'b1, 3'b001, 32'h1002, 32'h1234BEEF, 32'h0,        0, 0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
      tv[2]  = '{1'b0, 1'b1, 3'b010, 32'h1004, 32'h12345678, 32'h0,        0, 0, 1'b0, 4'b1111, 32'h12345678, 32'h0};
      tv[3]  = '{1'b1, 1'b0, 3'b000, 32'h2002, 32'h0,        32'h00800000, 0, 1, 1'b0, 4'b0100, 32'h0, 32'hFFFFFF80};
      tv[4]  = '{1'b1, 1'b0, 3'b100, 32'h2002, 32'h0,        32'h00800000, 0, 0, 1'b0, 4'b0100, 32'h0, 32'h00000080};
      tv[5]  = '{1'b1, 1'b0, 3'b001, 32'h2002, 32'h0,        32'h80010000, 1, 0, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001};
      tv[6]  = '{1'b1, 1'b0, 3'b101, 32'h2000, 32'h0,        32'h0000F00F, 0, 2, 1'b0, 4'b0011, 32'h0, 32'h0000F00F};
      tv[7]  = '{1'b1, 1'b0, 3'b010, 32'h2008, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF};
      tv[8]  = '{1'b0, 1'b1, 3'b000, 32'h3000, 32'hFFFFFF5A, 32'h0,        0, 0, 1'b0, 4'b0001, 32'h5A5A5A5A, 32'h0};
      tv[9]  = '{1'b1, 1'b0, 3'b001, 32'h2001, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
      tv[10] = '{1'b1, 1'b0, 3'b010, 32'h2002, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
      tv[11] = '{1'b1, 1'b0, 3'b011, 32'h2000, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
      tv[12] = '{1'b0, 1'b1, 3'b001, 32'h3003, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
      tv[13] = '{1'b1, 1'b0, 3'b000, 32'h3001, 32'h0,        32'h00007F00, 0, 0, 1'b0, 4'b0010, 32'h0, 32'h0000007F};
      tv[14] = '{1'b0, 1'b1, 3'b110, 32'h3000, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
      tv[15] = '{1'b1, 1'b0, 3'b101, 32'h2002, 32'h0,        32'h80011234, 0, 1, 1'b0, 4'b1100, 32'h0, 32'h00008001};

      rst = 1'b1; op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0; op_funct3 = 3'b000;
      op_addr = 32'h0; op_wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      last_load = 32'h0;
      #1;
      chk("rst_req", 0, 32'(bus_req), 32'd0);
      chk("rst_done", 0, 32'(done), 32'd0);
      chk("rst_load", 0, load_data, 32'h0);
      chk("rst_stall", 0, 32'(stall), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) do_op(tv[i], i);

      // Reset while waiting for grant drops the request at once.
      @(negedge clk);
      op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_funct3 = 3'b010; op_addr = 32'h50;
      @(negedge clk);
      chk("seqA_req", 0, 32'(bus_req), 32'd1);
      op_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("seqA_req_rst", 0, 32'(bus_req), 32'd0);
      chk("seqA_be_rst", 0, 32'(bus_be), 32'd0);
      chk("seqA_addr_rst", 0, bus_addr, 32'h0);
      chk("seqA_stall_rst", 0, 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_load = 32'h0;

      // Reset in WAIT_RSP, late rvalid ignored, new LW accepted on first edge.
      do_op(tv[7], 100);
      @(negedge clk);
      op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_funct3 = 3'b010; op_addr = 32'h60;
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      chk("seqB_wait_rsp_stall", 0, 32'(stall), 32'd1);
      op_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("seqB_req_rst", 0, 32'(bus_req), 32'd0);
      chk("seqB_done_rst", 0, 32'(done), 32'd0);
      chk("seqB_load_rst", 0, load_data, 32'h0);
      chk("seqB_stall_rst", 0, 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
      op_valid = 1'b1; op_addr = 32'h70;
      #1;
      chk("seqB_start_stall", 0, 32'(stall), 32'd1);
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      chk("seqB_late_done", 0, 32'(done), 32'd0);
      chk("seqB_late_load", 0, load_data, 32'h0);
      chk("seqB_new_req", 0, 32'(bus_req), 32'd1);
      chk("seqB_new_addr", 0, bus_addr, 32'h70);
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      #1;
      chk("seqB_new_done", 0, 32'(done), 32'd1);
      chk("seqB_new_load", 0, load_data, 32'h0BADF00D);
      op_valid = 1'b0;
      last_load = 32'h0BADF00D;

      do_op(tv[2], 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
